issue_scheduler: RTL and testbench

- Per-cycle scheduler that selects ready reservation-buffer entries (the entries written by dispatch) for execution.
- Owns two resources: a single-issue ALU/branch execution slot, and the one shared data-memory port. The memory port is sequenced by a request/response FSM.
- Enforces store ordering through the `number_of_early_store_ops` field.
- Reports completions back to the buffer-update logic.

---
 rtl/issue_scheduler_if.sv | 33 +++
 rtl/issue_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Memory-side bus of the issue scheduler.
// Carries the request/response handshake with the shared data-memory port and
// the completion report to the buffer-update logic.
//   master (scheduler): drives mem_req_*, mem_done_*; samples mem_req_ready, mem_rsp_*
//   slave  (memory/buffer side): the opposite directions
interface issue_scheduler_if #(
  parameter int IDX_W  = 3,
  parameter int RWMM_W = 3
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [RWMM_W-1:0] mem_req_rwmm;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              mem_done_valid;
  logic [IDX_W-1:0]  mem_done_index;
  logic [31:0]       mem_done_result;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_rwmm,
    output mem_done_valid, mem_done_index, mem_done_result,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_rwmm,
    input  mem_done_valid, mem_done_index, mem_done_result,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/issue_scheduler.sv
// Issue scheduler: picks ready reservation-buffer entries for execution.
// Owns a single-issue ALU/branch slot and the shared data-memory port (sequenced
// by an IDLE/REQ/WAIT/DONE FSM), enforces store ordering via a completed-store
// counter, and reports memory completions.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_entries           current buffer contents
//   i_flush_valid       branch mispredict kill
//   i_flush_spectag     kill mask, matched against speculative_tag
//   i_alu_ready         ALU/branch unit accepts an issue this cycle
//   o_alu_issue_valid   registered ALU/branch issue
//   o_alu_issue_index   issued entry index
//   mem                 memory request/response and completion bus (master)
package issue_scheduler_pkg;
  localparam int BUF_SIZE     = 8;
  localparam int BUF_SIZE_LOG = 3;

  typedef logic [BUF_SIZE_LOG-1:0] index_t;

  typedef enum logic [1:0] {S_EMPTY, S_NOT_EXECUTED, S_EXECUTING, S_EXECUTED} estate_t;
  typedef enum logic [2:0] {U_ALU, U_BRANCH, U_LOAD, U_STORE, U_MUL} unit_t;

  typedef struct packed {
    estate_t     e_state;
    logic        J_rdy;
    logic        K_rdy;
    unit_t       unit;
    index_t      number_of_early_store_ops;
    logic [5:0]  speculative_tag;
    logic [5:0]  tag;
    logic [31:0] Vj;
    logic [31:0] Vk;
    logic [31:0] A;
    logic [2:0]  rwmm;
  } entry_t;
endpackage

module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  entry_t              i_entries [BUF_SIZE],
  input  logic                i_flush_valid,
  input  logic [5:0]          i_flush_spectag,
  input  logic                i_alu_ready,
  output logic                o_alu_issue_valid,
  output index_t              o_alu_issue_index,
  issue_scheduler_if.master   mem
);

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT, M_DONE} mstate_t;

  function automatic logic f_killed(input logic [5:0] spectag, input logic fv,
                                    input logic [5:0] mask);
    return fv && ((spectag & mask) != 6'd0);
  endfunction

  logic        r_alu_valid;
  index_t      r_alu_index;
  mstate_t     r_state;
  logic        r_kill;
  index_t      r_store_cnt;
  index_t      r_mem_index;
  logic        r_req_valid;
  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [2:0]  r_req_rwmm;
  logic [5:0]  r_spec;
  logic        r_done_valid;
  logic [31:0] r_done_result;

  logic        w_alu_found;
  index_t      w_alu_sel;
  logic [5:0]  w_alu_tag;
  logic        w_alu_kill;
  logic        w_mem_found;
  index_t      w_mem_sel;
  logic [5:0]  w_mem_tag;
  logic        w_ready;
  logic        w_is_mem;
  logic        w_alu_cand;
  logic        w_mem_cand;
  logic        w_kill_now;

  // Oldest-ready selection for both paths; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_alu_found = 1'b0;
    w_alu_sel   = '0;
    w_alu_tag   = 6'd0;
    w_mem_found = 1'b0;
    w_mem_sel   = '0;
    w_mem_tag   = 6'd0;
    w_ready     = 1'b0;
    w_is_mem    = 1'b0;
    w_alu_cand  = 1'b0;
    w_mem_cand  = 1'b0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      w_ready  = (i_entries[i].e_state == S_NOT_EXECUTED) && i_entries[i].J_rdy && i_entries[i].K_rdy;
      w_is_mem = (i_entries[i].unit == U_LOAD) || (i_entries[i].unit == U_STORE);
      // The presented index is still NOT_EXECUTED in the buffer for one more cycle.
      w_alu_cand = w_ready && !w_is_mem &&
                   !(r_alu_valid && (r_alu_index == index_t'(i))) &&
                   (!w_alu_found || (i_entries[i].tag > w_alu_tag));
      w_mem_cand = w_ready && w_is_mem &&
                   (i_entries[i].number_of_early_store_ops == r_store_cnt) &&
                   ((i_entries[i].unit != U_STORE) || (i_entries[i].speculative_tag == 6'd0)) &&
                   (!w_mem_found || (i_entries[i].tag > w_mem_tag));
      w_alu_sel   = w_alu_cand ? index_t'(i) : w_alu_sel;
      w_alu_tag   = w_alu_cand ? i_entries[i].tag : w_alu_tag;
      w_alu_found = w_alu_found || w_alu_cand;
      w_mem_sel   = w_mem_cand ? index_t'(i) : w_mem_sel;
      w_mem_tag   = w_mem_cand ? i_entries[i].tag : w_mem_tag;
      w_mem_found = w_mem_found || w_mem_cand;
    end
    w_alu_kill = f_killed(i_entries[w_alu_sel].speculative_tag, i_flush_valid, i_flush_spectag);
    w_kill_now = f_killed(r_spec, i_flush_valid, i_flush_spectag);
  end

  // ALU/branch issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_valid <= 1'b0;
      r_alu_index <= '0;
    end else if (w_alu_found && i_alu_ready && !w_alu_kill) begin
      r_alu_valid <= 1'b1;
      r_alu_index <= w_alu_sel;
    end else begin
      r_alu_valid <= 1'b0;
    end
  end

  // Memory-port FSM with registered request and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= M_IDLE;
      r_kill        <= 1'b0;
      r_store_cnt   <= '0;
      r_mem_index   <= '0;
      r_req_valid   <= 1'b0;
      r_req_we      <= 1'b0;
      r_req_addr    <= 32'd0;
      r_req_wdata   <= 32'd0;
      r_req_rwmm    <= 3'd0;
      r_spec        <= 6'd0;
      r_done_valid  <= 1'b0;
      r_done_result <= 32'd0;
    end else begin
      case (r_state)
        M_IDLE: begin
          r_kill <= 1'b0;
          if (w_mem_found && !i_flush_valid) begin
            r_mem_index <= w_mem_sel;
            r_req_addr  <= i_entries[w_mem_sel].Vj + i_entries[w_mem_sel].A;
            r_req_we    <= (i_entries[w_mem_sel].unit == U_STORE);
            r_req_wdata <= (i_entries[w_mem_sel].unit == U_STORE) ? i_entries[w_mem_sel].Vk : 32'd0;
            r_req_rwmm  <= i_entries[w_mem_sel].rwmm;
            r_spec      <= i_entries[w_mem_sel].speculative_tag;
            r_req_valid <= 1'b1;
            r_state     <= M_REQ;
          end
        end
        M_REQ: begin
          // A killed request still finishes its handshake; only the report is dropped.
          if (w_kill_now) r_kill <= 1'b1;
          if (mem.mem_req_ready) begin
            r_req_valid <= 1'b0;
            if (!r_req_we) begin
              r_state <= M_WAIT;
            end else if (r_kill || w_kill_now) begin
              r_state <= M_IDLE;
            end else begin
              r_done_valid  <= 1'b1;
              r_done_result <= 32'd0;
              r_state       <= M_DONE;
            end
          end
        end
        M_WAIT: begin
          if (mem.mem_rsp_valid) begin
            if (r_kill || w_kill_now) begin
              r_state <= M_IDLE;
            end else begin
              r_done_valid  <= 1'b1;
              r_done_result <= mem.mem_rsp_data;
              r_state       <= M_DONE;
            end
          end else if (w_kill_now) begin
            r_kill <= 1'b1;
          end
        end
        M_DONE: begin
          r_done_valid <= 1'b0;
          if (r_req_we) r_store_cnt <= r_store_cnt + index_t'(1);
          r_state <= M_IDLE;
        end
        default: begin
          r_state <= M_IDLE;
        end
      endcase
    end
  end

  assign o_alu_issue_valid   = r_alu_valid;
  assign o_alu_issue_index   = r_alu_index;
  assign mem.mem_req_valid   = r_req_valid;
  assign mem.mem_req_we      = r_req_we;
  assign mem.mem_req_addr    = r_req_addr;
  assign mem.mem_req_wdata   = r_req_wdata;
  assign mem.mem_req_rwmm    = r_req_rwmm;
  assign mem.mem_done_valid  = r_done_valid;
  assign mem.mem_done_index  = r_mem_index;
  assign mem.mem_done_result = r_done_result;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: ALU selection/exclusion/flush, load and
// store sequencing, store ordering, speculative store hold-off, killed load and
// mid-transaction reset.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  entry_t     ents [BUF_SIZE];
  logic       flush_valid;
  logic [5:0] flush_spectag;
  logic       alu_ready;
  logic       alu_v;
  index_t     alu_i;
  int         checks = 0;
  int         errors = 0;

  issue_scheduler_if #(.IDX_W(BUF_SIZE_LOG), .RWMM_W(3)) mif ();

  issue_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .i_entries         (ents),
    .i_flush_valid     (flush_valid),
    .i_flush_spectag   (flush_spectag),
    .i_alu_ready       (alu_ready),
    .o_alu_issue_valid (alu_v),
    .o_alu_issue_index (alu_i),
    .mem               (mif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < BUF_SIZE; i++) ents[i] = '0;
  endtask

  function automatic entry_t mk(input unit_t u, input logic [5:0] tag, input logic [5:0] st,
                                input index_t nes, input logic [31:0] vj,
                                input logic [31:0] vk, input logic [31:0] a);
    entry_t e;
    e = '0;
    e.e_state = S_NOT_EXECUTED;
    e.J_rdy = 1'b1;
    e.K_rdy = 1'b1;
    e.unit = u;
    e.tag = tag;
    e.speculative_tag = st;
    e.number_of_early_store_ops = nes;
    e.Vj = vj;
    e.Vk = vk;
    e.A = a;
    e.rwmm = 3'b010;
    return e;
  endfunction

  initial begin
    rst = 1'b1;
    flush_valid = 1'b0;
    flush_spectag = 6'd0;
    alu_ready = 1'b1;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data = 32'd0;
    clear_all();
    tick();
    tick();
    chk("rst_alu_v", 32'(alu_v), 32'd0);
    chk("rst_req_v", 32'(mif.mem_req_valid), 32'd0);
    chk("rst_done_v", 32'(mif.mem_done_valid), 32'd0);
    chk("rst_done_res", mif.mem_done_result, 32'd0);
    rst = 1'b0;

    // ALU: oldest first, then the next one while the first is still shown ready
    ents[2] = mk(U_ALU, 6'd15, 6'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    ents[5] = mk(U_ALU, 6'd12, 6'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("alu1_v", 32'(alu_v), 32'd1);
    chk("alu1_idx", 32'(alu_i), 32'd2);
    tick();
    chk("alu2_v", 32'(alu_v), 32'd1);
    chk("alu2_idx", 32'(alu_i), 32'd5);
    ents[2].e_state = S_EXECUTING;
    tick();
    chk("alu3_v", 32'(alu_v), 32'd0);
    ents[5].e_state = S_EXECUTING;
    tick();
    chk("alu4_v", 32'(alu_v), 32'd0);

    // Equal tags: lowest index
    clear_all();
    ents[4] = mk(U_ALU, 6'd9, 6'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    ents[1] = mk(U_BRANCH, 6'd9, 6'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("tie_idx", 32'(alu_i), 32'd1);
    clear_all();
    tick();

    // alu_ready low blocks issue
    ents[3] = mk(U_MUL, 6'd4, 6'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    alu_ready = 1'b0;
    tick();
    chk("alu_nrdy_v", 32'(alu_v), 32'd0);
    alu_ready = 1'b1;
    tick();
    chk("alu_rdy_idx", 32'(alu_i), 32'd3);
    clear_all();
    tick();

    // Flush matching the candidate suppresses; non-matching mask does not
    ents[6] = mk(U_BRANCH, 6'd3, 6'b000100, 3'd0, 32'd0, 32'd0, 32'd0);
    flush_valid = 1'b1;
    flush_spectag = 6'b000100;
    tick();
    chk("alu_flush_v", 32'(alu_v), 32'd0);
    flush_spectag = 6'b000010;
    tick();
    chk("alu_nflush_v", 32'(alu_v), 32'd1);
    chk("alu_nflush_idx", 32'(alu_i), 32'd6);
    flush_valid = 1'b0;
    flush_spectag = 6'd0;
    clear_all();
    tick();

    // Load with back-pressure, then response
    ents[0] = mk(U_LOAD, 6'd20, 6'd0, 3'd0, 32'h100, 32'h55, 32'h8);
    tick();
    chk("ld_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("ld_addr", mif.mem_req_addr, 32'h108);
    chk("ld_we", 32'(mif.mem_req_we), 32'd0);
    chk("ld_wdata", mif.mem_req_wdata, 32'd0);
    chk("ld_rwmm", 32'(mif.mem_req_rwmm), 32'd2);
    tick();
    chk("ld_hold_v", 32'(mif.mem_req_valid), 32'd1);
    chk("ld_hold_addr", mif.mem_req_addr, 32'h108);
    tick();
    chk("ld_hold2_v", 32'(mif.mem_req_valid), 32'd1);
    mif.mem_req_ready = 1'b1;
    tick();
    chk("ld_acc_v", 32'(mif.mem_req_valid), 32'd0);
    chk("ld_nodone", 32'(mif.mem_done_valid), 32'd0);
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_data = 32'hDEADBEEF;
    tick();
    chk("ld_done_v", 32'(mif.mem_done_valid), 32'd1);
    chk("ld_done_idx", 32'(mif.mem_done_index), 32'd0);
    chk("ld_done_res", mif.mem_done_result, 32'hDEADBEEF);
    mif.mem_rsp_valid = 1'b0;
    ents[0].e_state = S_EXECUTED;
    tick();
    chk("ld_pulse_end", 32'(mif.mem_done_valid), 32'd0);
    tick();
    chk("ld_idle_req", 32'(mif.mem_req_valid), 32'd0);

    // Store ordering: nes=1 store waits for the nes=0 store
    mif.mem_req_ready = 1'b1;
    ents[1] = mk(U_STORE, 6'd10, 6'd0, 3'd1, 32'h300, 32'h12345678, 32'h10);
    ents[3] = mk(U_STORE, 6'd30, 6'd0, 3'd0, 32'h200, 32'hCAFE0001, 32'h4);
    tick();
    chk("st0_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("st0_we", 32'(mif.mem_req_we), 32'd1);
    chk("st0_addr", mif.mem_req_addr, 32'h204);
    chk("st0_wdata", mif.mem_req_wdata, 32'hCAFE0001);
    tick();
    chk("st0_done_v", 32'(mif.mem_done_valid), 32'd1);
    chk("st0_done_idx", 32'(mif.mem_done_index), 32'd3);
    chk("st0_done_res", mif.mem_done_result, 32'd0);
    ents[3].e_state = S_EXECUTED;
    tick();
    chk("st1_not_yet", 32'(mif.mem_req_valid), 32'd0);
    tick();
    chk("st1_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("st1_addr", mif.mem_req_addr, 32'h310);
    chk("st1_wdata", mif.mem_req_wdata, 32'h12345678);
    tick();
    chk("st1_done_idx", 32'(mif.mem_done_index), 32'd1);
    ents[1].e_state = S_EXECUTED;
    tick();

    // Speculative store held off until its tag clears (also needs store_cnt == 2)
    ents[4] = mk(U_STORE, 6'd5, 6'b000001, 3'd2, 32'h400, 32'hA5A5A5A5, 32'h0);
    tick();
    chk("sst_held1", 32'(mif.mem_req_valid), 32'd0);
    tick();
    chk("sst_held2", 32'(mif.mem_req_valid), 32'd0);
    ents[4].speculative_tag = 6'd0;
    tick();
    chk("sst_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("sst_addr", mif.mem_req_addr, 32'h400);
    chk("sst_wdata", mif.mem_req_wdata, 32'hA5A5A5A5);
    tick();
    chk("sst_done_idx", 32'(mif.mem_done_index), 32'd4);
    ents[4].e_state = S_EXECUTED;
    tick();

    // Speculative load killed while waiting for its response
    ents[6] = mk(U_LOAD, 6'd7, 6'b000010, 3'd3, 32'h600, 32'h0, 32'h20);
    tick();
    chk("kld_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("kld_addr", mif.mem_req_addr, 32'h620);
    tick();
    chk("kld_acc_v", 32'(mif.mem_req_valid), 32'd0);
    flush_valid = 1'b1;
    flush_spectag = 6'b000010;
    tick();
    chk("kld_flush_done", 32'(mif.mem_done_valid), 32'd0);
    flush_valid = 1'b0;
    flush_spectag = 6'd0;
    ents[6] = '0;
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_data = 32'h11112222;
    tick();
    chk("kld_rsp_done", 32'(mif.mem_done_valid), 32'd0);
    mif.mem_rsp_valid = 1'b0;
    tick();
    chk("kld_after_done", 32'(mif.mem_done_valid), 32'd0);
    chk("kld_after_req", 32'(mif.mem_req_valid), 32'd0);

    // store_cnt is still 3; then reset mid-request
    mif.mem_req_ready = 1'b0;
    ents[7] = mk(U_LOAD, 6'd8, 6'd0, 3'd3, 32'h700, 32'h0, 32'h1);
    tick();
    chk("rld_req_v", 32'(mif.mem_req_valid), 32'd1);
    chk("rld_addr", mif.mem_req_addr, 32'h701);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req_v", 32'(mif.mem_req_valid), 32'd0);
    chk("mrst_done_v", 32'(mif.mem_done_valid), 32'd0);
    tick();
    chk("mrst_cnt_block", 32'(mif.mem_req_valid), 32'd0);
    chk("mrst_no_done", 32'(mif.mem_done_valid), 32'd0);
    ents[0] = mk(U_LOAD, 6'd3, 6'd0, 3'd0, 32'h10, 32'h0, 32'h10);
    tick();
    chk("mrst_cnt0_req", 32'(mif.mem_req_valid), 32'd1);
    chk("mrst_cnt0_addr", mif.mem_req_addr, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
